// File: rtl/rom_loader_pkg.sv
// Shared constants and loader state encoding for the SPI EEPROM ROM loader.
package rom_loader_pkg;

  localparam int          DEF_ROM_DEPTH  = 1024;
  localparam int          DEF_ADDR_WIDTH = 10;
  localparam int          DEF_SPI_DIV    = 4;
  localparam logic [15:0] DEF_EE_BASE    = 16'h0000;
  localparam logic [7:0]  DEF_READ_CMD   = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_CS_HOLD,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic is_active(input state_t s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

endpackage

// File: rtl/rom_loader_spi_byte_engine.sv
// SCK divider plus 8-bit SPI mode-0 shifter with a continuous byte stream.
module spi_byte_engine #(
  parameter int SPI_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic       en_i,
  input  logic       run_i,
  input  logic [7:0] tx_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       tick_o,
  output logic       byte_done_o,
  output logic [7:0] rx_o
);

  localparam int DW = $clog2(SPI_DIV);

  logic [DW-1:0] div_q, div_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          sck_q, sck_d;

  assign tick_o      = en_i && (div_q == DW'(SPI_DIV - 1));
  assign byte_done_o = run_i && tick_o && sck_q && (cnt_q == 4'd8);
  assign sck_o       = sck_q;
  assign mosi_o      = tx_q[7];
  assign rx_o        = rx_q;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    tx_d  = tx_q;
    rx_d  = rx_q;
    sck_d = sck_q;
    if (en_i) div_d = tick_o ? '0 : div_q + 1'b1;
    // Rise samples MISO; fall shifts MOSI or hands over to the next byte.
    if (run_i && tick_o) begin
      sck_d = !sck_q;
      if (!sck_q) begin
        rx_d  = {rx_q[6:0], miso_i};
        cnt_d = cnt_q + 4'd1;
      end else if (cnt_q == 4'd8) begin
        tx_d  = tx_i;
        cnt_d = '0;
      end else begin
        tx_d = {tx_q[6:0], 1'b0};
      end
    end
    if (ld_i) begin
      div_d = '0;
      cnt_d = '0;
      sck_d = 1'b0;
      tx_d  = tx_i;
    end
    if (clr_i) begin
      div_d = '0;
      cnt_d = '0;
      sck_d = 1'b0;
      tx_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      cnt_q <= '0;
      tx_q  <= '0;
      rx_q  <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Copies a program image from a 25xx SPI EEPROM into the core ROM,
// holding the core until the image is written or found blank.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int          ROM_DEPTH  = DEF_ROM_DEPTH,
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int          SPI_DIV    = DEF_SPI_DIV,
  parameter logic [15:0] EE_BASE    = DEF_EE_BASE,
  parameter logic [7:0]  READ_CMD   = DEF_READ_CMD
) (
  input  logic                  raw_clk,
  input  logic                  button_reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  spi_cs_n,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_waddr,
  output logic [7:0]            rom_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ab_q, ab_d;
  logic                  b0ff_q, b0ff_d;
  logic                  active, start_ok, run;
  logic                  tick, byte_done;
  logic [7:0]            tx, rx;

  assign active   = is_active(state_q);
  assign start_ok = start && !abort && !active;
  assign run      = state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_WRITE};

  spi_byte_engine #(
    .SPI_DIV(SPI_DIV)
  ) u_eng (
    .clk_i      (raw_clk),
    .rst_ni     (button_reset),
    .clr_i      (abort),
    .ld_i       (start_ok),
    .en_i       (active),
    .run_i      (run),
    .tx_i       (tx),
    .miso_i     (spi_miso),
    .sck_o      (spi_sck),
    .mosi_o     (spi_mosi),
    .tick_o     (tick),
    .byte_done_o(byte_done),
    .rx_o       (rx)
  );

  // Byte handed to the shifter at the fall that closes the current byte.
  always_comb begin
    tx = READ_CMD;
    case (state_q)
      ST_CMD:                      tx = EE_BASE[15:8];
      ST_ADDR:                     tx = ab_q ? 8'h00 : EE_BASE[7:0];
      ST_DATA, ST_WRITE, ST_CS_HOLD: tx = 8'h00;
      default:                     tx = READ_CMD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ab_d    = ab_q;
    b0ff_d  = b0ff_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok) begin
          state_d = ST_CS_SETUP;
          idx_d   = '0;
          ab_d    = 1'b0;
          b0ff_d  = 1'b0;
        end
      end
      ST_CS_SETUP: if (tick) state_d = ST_CMD;
      ST_CMD:      if (byte_done) state_d = ST_ADDR;
      ST_ADDR: begin
        if (byte_done) begin
          ab_d = 1'b1;
          if (ab_q) state_d = ST_DATA;
        end
      end
      ST_DATA:     if (byte_done) state_d = ST_WRITE;
      ST_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '0) b0ff_d = (rx == 8'hff);
        if (idx_q == ADDR_WIDTH'(1) && b0ff_q && rx == 8'hff)
          state_d = ST_ERROR;
        else if (idx_q == ADDR_WIDTH'(ROM_DEPTH - 1))
          state_d = ST_CS_HOLD;
        else
          state_d = ST_DATA;
      end
      ST_CS_HOLD:  if (tick) state_d = ST_DONE;
      default:     state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ab_q    <= 1'b0;
      b0ff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
      b0ff_q  <= b0ff_d;
    end
  end

  assign spi_cs_n  = !active;
  assign cpu_hold  = active;
  assign busy      = active;
  assign rom_we    = (state_q == ST_WRITE);
  assign rom_waddr = idx_q;
  assign rom_wdata = rx;
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: behavioural SPI EEPROM plus expected-image model.
`timescale 1ns/1ps
module tb_rom_loader;

  localparam int          DEPTH  = 128;
  localparam int          AW     = 7;
  localparam int          DIV    = 3;
  localparam logic [15:0] BASE   = 16'h0105;
  localparam logic [7:0]  CMD    = 8'h03;
  localparam int          RISES  = 24 + 8 * DEPTH;
  localparam int          BUDGET = RISES * 2 * DIV + 200;

  logic          raw_clk = 1'b0;
  logic          button_reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          spi_miso = 1'b0;
  logic          spi_cs_n, spi_sck, spi_mosi;
  logic          rom_we, cpu_hold, busy, done, error;
  logic [AW-1:0] rom_waddr;
  logic [7:0]    rom_wdata;

  int          checks = 0;
  int          errors = 0;
  int          mode = 0;
  logic [7:0]  rnd_mem [1024];
  int          rises = 0;
  int          nb = 0;
  logic [23:0] hdr = '0;
  int          wa_q[$];
  int          wd_q[$];
  int          dbl = 0;
  logic        prev_we = 1'b0;

  rom_loader #(
    .ROM_DEPTH (DEPTH),
    .ADDR_WIDTH(AW),
    .SPI_DIV   (DIV),
    .EE_BASE   (BASE),
    .READ_CMD  (CMD)
  ) dut (
    .raw_clk     (raw_clk),
    .button_reset(button_reset),
    .start       (start),
    .abort       (abort),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .rom_we      (rom_we),
    .rom_waddr   (rom_waddr),
    .rom_wdata   (rom_wdata),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 raw_clk = ~raw_clk;

  function automatic logic [7:0] ee_byte(input logic [15:0] a);
    case (mode)
      0:       return a[7:0];
      1:       return rnd_mem[a[9:0]];
      default: return 8'hff;
    endcase
  endfunction

  always @(negedge spi_cs_n) nb = 0;

  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      rises++;
      if (nb < 24) hdr = {hdr[22:0], spi_mosi};
      nb++;
    end
  end

  always @(negedge spi_sck) begin
    logic [7:0] b;
    logic [2:0] bi;
    int k;
    if (!spi_cs_n && nb >= 24) begin
      k = nb - 24;
      b = ee_byte(hdr[15:0] + 16'(k / 8));
      bi = 3'(7 - k % 8);
      spi_miso = b[bi];
    end
  end

  always @(negedge raw_clk) begin
    if (rom_we) begin
      wa_q.push_back(int'(rom_waddr));
      wd_q.push_back(int'(rom_wdata));
      if (prev_we) dbl++;
    end
    prev_we = rom_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
    dbl = 0;
    rises = 0;
  endtask

  task automatic pulse_start();
    @(negedge raw_clk) start = 1'b1;
    @(posedge raw_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge raw_clk);
    while (busy && n < BUDGET) begin
      @(negedge raw_clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_writes(input string tag, input int k);
    int n = 0;
    while (wa_q.size() < k && n < BUDGET) begin
      @(negedge raw_clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(wa_q.size() >= k), 32'd1);
  endtask

  task automatic check_image(input string tag, input int n);
    int bad = 0;
    logic [7:0] ed;
    chk({tag, "_we_count"}, wa_q.size(), n);
    foreach (wa_q[i]) begin
      ed = ee_byte(BASE + 16'(i));
      if (wa_q[i] != i || wd_q[i] != int'(ed)) bad++;
    end
    chk({tag, "_image"}, bad, 0);
    chk({tag, "_double_we"}, dbl, 0);
  endtask

  task automatic full_load(input string tag);
    clr_log();
    pulse_start();
    chk({tag, "_started"},
        32'({busy, cpu_hold, spi_cs_n, done, error}), 32'(5'b11000));
    wait_idle(tag);
    check_image(tag, DEPTH);
    chk({tag, "_rises"}, rises, RISES);
    chk({tag, "_header"}, 32'(hdr), 32'({CMD, BASE}));
    chk({tag, "_final"},
        32'({done, error, busy, cpu_hold, spi_cs_n, spi_sck}),
        32'(6'b100010));
  endtask

  initial begin
    int k;
    int n;
    foreach (rnd_mem[i]) rnd_mem[i] = 8'($urandom);

    repeat (3) @(negedge raw_clk);
    chk("reset_out",
        32'({spi_cs_n, spi_sck, spi_mosi, rom_we, cpu_hold, busy, done, error}),
        32'(8'b10000000));
    chk("reset_addr_data", 32'({rom_waddr, rom_wdata}), 32'd0);
    @(negedge raw_clk) button_reset = 1'b1;
    repeat (2) @(negedge raw_clk);
    chk("idle_after_reset", 32'({busy, spi_cs_n}), 32'(2'b01));

    mode = 0;
    full_load("pattern");

    mode = 1;
    full_load("random");

    mode = 2;
    clr_log();
    pulse_start();
    wait_idle("blank");
    chk("blank_we_count", wa_q.size(), 2);
    chk("blank_flags", 32'({error, done, busy, cpu_hold, spi_cs_n}),
        32'(5'b10001));
    chk("blank_rises", rises, 40);
    chk("blank_double_we", dbl, 0);

    mode = 0;
    clr_log();
    pulse_start();
    chk("restart_clears_error", 32'({error, busy}), 32'(2'b01));
    k = $urandom_range(20, DEPTH - 20);
    wait_writes("abort_wait", k);
    @(negedge raw_clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge raw_clk);
    #1;
    chk("abort_out",
        32'({spi_cs_n, spi_sck, rom_we, busy, cpu_hold, done, error}),
        32'(7'b1000000));
    n = wa_q.size();
    @(negedge raw_clk);
    abort = 1'b0;
    start = 1'b0;
    repeat (4 * DIV) @(negedge raw_clk);
    chk("abort_frozen", wa_q.size(), n);
    chk("abort_prefix_ok", 32'(n >= k && n < DEPTH), 32'd1);
    @(negedge raw_clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge raw_clk);
    #1;
    chk("abort_beats_start", 32'({busy, spi_cs_n}), 32'(2'b01));
    @(negedge raw_clk);
    abort = 1'b0;
    start = 1'b0;
    full_load("after_abort");

    mode = 1;
    foreach (rnd_mem[i]) rnd_mem[i] = 8'($urandom);
    clr_log();
    pulse_start();
    wait_writes("busy_wait", 10);
    pulse_start();
    chk("start_while_busy", 32'({busy, cpu_hold}), 32'(2'b11));
    wait_idle("busy_start");
    check_image("busy_start", DEPTH);
    chk("busy_start_rises", rises, RISES);

    mode = 0;
    clr_log();
    pulse_start();
    wait_writes("rst_wait", 60);
    @(negedge raw_clk);
    #2 button_reset = 1'b0;
    #1;
    chk("midload_reset_out",
        32'({spi_cs_n, spi_sck, spi_mosi, rom_we, cpu_hold, busy, done, error}),
        32'(8'b10000000));
    chk("midload_reset_addr", 32'(rom_waddr), 32'd0);
    n = wa_q.size();
    repeat (3) @(negedge raw_clk);
    chk("midload_no_we", wa_q.size(), n);
    button_reset = 1'b1;
    repeat (2 * DIV) @(negedge raw_clk);
    chk("midload_stays_idle", 32'({busy, done, spi_cs_n}), 32'(3'b001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
